// File: rtl/sev_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner: frame-synchronous double-buffered
// display data, 8-level PWM brightness and leading-zero suppression.
module sev_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int SUB_DIV    = 12500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic                    hex_mode,
    input  logic [2:0]              brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start,
    output logic                    update_pending
);

    localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SUB_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] pre;
    logic [2:0]    sub;
    logic [IW-1:0] idx;
    logic          pre_wrap, sub_wrap, boundary, boundary_q;

    logic [4*NUM_DIGITS-1:0] pend_bcd, act_bcd;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank;

    logic [NUM_DIGITS-1:0] supp;
    logic                  scanning;
    logic [3:0]            cur_code;
    logic                  cur_dp, cur_dark, lit;
    logic [NUM_DIGITS-1:0] an_next;

    assign pre_wrap = enable && (pre == PRE_MAX);
    assign sub_wrap = pre_wrap && (sub == 3'd7);
    assign boundary = sub_wrap && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre        <= '0;
            sub        <= '0;
            idx        <= '0;
            boundary_q <= 1'b0;
        end else if (enable) begin
            pre        <= pre_wrap ? '0 : pre + 1'b1;
            boundary_q <= boundary;
            if (pre_wrap)
                sub <= sub + 3'd1;
            if (sub_wrap)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses pending so it is not lost for a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_bcd       <= '0;
            pend_dp        <= '0;
            pend_blank     <= '1;
            act_bcd        <= '0;
            act_dp         <= '0;
            act_blank      <= '1;
            update_pending <= 1'b0;
        end else if (load && boundary) begin
            pend_bcd       <= bcd_in;
            pend_dp        <= dp_in;
            pend_blank     <= blank_in;
            act_bcd        <= bcd_in;
            act_dp         <= dp_in;
            act_blank      <= blank_in;
            update_pending <= 1'b0;
        end else if (load) begin
            pend_bcd       <= bcd_in;
            pend_dp        <= dp_in;
            pend_blank     <= blank_in;
            update_pending <= 1'b1;
        end else if (boundary && update_pending) begin
            act_bcd        <= pend_bcd;
            act_dp         <= pend_dp;
            act_blank      <= pend_blank;
            update_pending <= 1'b0;
        end
    end

    // Blanked digits are skipped by the scan rather than terminating it.
    always_comb begin
        supp     = '0;
        scanning = lz_suppress;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (scanning && !act_blank[k]) begin
                if (act_bcd[4*k +: 4] == 4'd0 && !act_dp[k])
                    supp[k] = 1'b1;
                else
                    scanning = 1'b0;
            end
        end
    end

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code = act_bcd[4*k +: 4];
                cur_dp   = act_dp[k];
                cur_dark = act_blank[k] | supp[k];
            end
        end
    end

    assign lit = enable && !cur_dark && (sub <= brightness);

    always_comb begin
        an_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++)
            an_next[k] = !(lit && idx == IW'(k));
    end

    function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        if (!hex && code >= 4'd10)
            s = 7'h3F;
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out     <= 7'h7F;
            dp_out      <= 1'b1;
            an_out      <= '1;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= lit ? decode(cur_code, hex_mode) : 7'h7F;
            dp_out      <= ~(lit & cur_dp);
            an_out      <= an_next;
            frame_start <= boundary_q & enable;
        end
    end

endmodule
